// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// result = {remainder, quotient}; the remainder takes the sign of the dividend.
//
// state  | meaning
// -------+------------------------------------------------------------
// FREE   | idle, waiting for start; outputs held at zero
// BYZERO | divisor was zero; next edge presents a zero result
// ON     | one restoring step per edge until the counter reaches WIDTH
// END    | result presented and held until start is dropped
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [2*WIDTH:0]   work, work_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   divisor, divisor_n;
    logic               neg_rem, neg_rem_n;
    logic               neg_quo, neg_quo_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_abs, rem_abs, quo_fix, rem_fix;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FREE;
            work     <= '0;
            cnt      <= '0;
            divisor  <= '0;
            neg_rem  <= 1'b0;
            neg_quo  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            work     <= work_n;
            cnt      <= cnt_n;
            divisor  <= divisor_n;
            neg_rem  <= neg_rem_n;
            neg_quo  <= neg_quo_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    // Next-state, restoring step and sign fix-up of the final result.
    always_comb begin
        state_n   = state;
        work_n    = work;
        cnt_n     = cnt;
        divisor_n = divisor;
        neg_rem_n = neg_rem;
        neg_quo_n = neg_quo;
        result_n  = result_o;
        ready_n   = ready_o;

        // Magnitudes only matter in signed mode; DIVU takes operands as-is.
        a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
        b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

        shifted = {work[2*WIDTH-1:0], 1'b0};
        trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};

        quo_abs = work[WIDTH-1:0];
        rem_abs = work[2*WIDTH-1:WIDTH];
        quo_fix = neg_quo ? (~quo_abs + WIDTH'(1)) : quo_abs;
        rem_fix = neg_rem ? (~rem_abs + WIDTH'(1)) : rem_abs;

        unique case (state)
            FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                cnt_n    = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = BYZERO;
                    end else begin
                        state_n   = ON;
                        work_n    = {{(WIDTH+1){1'b0}}, a_abs};
                        divisor_n = b_abs;
                        neg_rem_n = signed_div_i & opdata1_i[WIDTH-1];
                        neg_quo_n = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    end
                end
            end
            BYZERO: begin
                result_n = '0;
                if (annul_i) begin
                    state_n = FREE;
                    ready_n = 1'b0;
                end else begin
                    state_n = END;
                    ready_n = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_n  = FREE;
                    cnt_n    = '0;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else if (cnt == CW'(WIDTH)) begin
                    state_n  = END;
                    result_n = {rem_fix, quo_fix};
                    ready_n  = 1'b1;
                end else begin
                    // A borrow out of the trial subtraction means the divisor did not fit.
                    work_n = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};
                    cnt_n  = cnt + CW'(1);
                end
            end
            END: begin
                if (!start_i) begin
                    state_n  = FREE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end
            default: begin
                state_n  = FREE;
                ready_n  = 1'b0;
                result_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed DIV/DIVU vectors, scoreboard queue checked by a monitor.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest queued expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && ready_o && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got result %h at cycle %0d, required no result", result_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, result_o, e.res);
                    chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                end
            end
            prev = ready_o;
        end
    end

    task automatic do_op(input string nm, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input int hold, input bit rst_end);
        int accept;
        int n;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        accept       = cyc + 1;
        sb.push_back('{exp, accept + lat, nm});
        // Operands change after acceptance; only latched values may be used.
        @(negedge clk);
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'h0;
        signed_div_i = ~sgn;
        n = 0;
        while (!ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got ready_o=0 after %0d cycles, required 1", nm, n);
        end
        repeat (hold) begin
            @(negedge clk);
            chk({nm, "_hold_ready"}, 64'(ready_o), 64'd1);
            chk({nm, "_hold_result"}, result_o, exp);
        end
        if (rst_end) begin
            #2 rst = 1'b0;
            #1;
            chk({nm, "_rst_end_ready"}, 64'(ready_o), 64'd0);
            chk({nm, "_rst_end_result"}, result_o, 64'd0);
            start_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end else begin
            start_i = 1'b0;
            @(negedge clk);
            chk({nm, "_drop_ready"}, 64'(ready_o), 64'd0);
            chk({nm, "_drop_result"}, result_o, 64'd0);
        end
    endtask

    initial begin
        int acc;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b1;

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 1, 1'b0);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1, 1'b0);
        do_op("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 1, 1'b0);
        do_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE}, 33, 1, 1'b0);
        do_op("div_5_0", 1'b1, 32'd5, 32'd0, 64'd0, 1, 1, 1'b0);

        // Annul at edge 10 of a DIVU; no result may appear.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'h10;
        start_i      = 1'b1;
        acc          = cyc + 1;
        while (cyc < acc + 9) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_ready_now", 64'(ready_o), 64'd0);
        repeat (40) @(negedge clk);
        chk("annul_ready_later", 64'(ready_o), 64'd0);
        do_op("divu_ffffffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 1, 1'b0);

        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1, 1'b0);
        do_op("divu_8000_ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33, 1, 1'b0);

        // Asynchronous reset in the middle of an ON sequence.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        acc          = cyc + 1;
        while (cyc < acc + 19) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_on_ready", 64'(ready_o), 64'd0);
        chk("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_on_no_result", 64'(ready_o), 64'd0);

        do_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 5, 1'b0);
        do_op("divu_100_7_rst", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 2, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 integer divider for the execute stage. Serves MIPS DIV/DIVU.
- The execute stage holds start_i high and stalls the pipeline until ready_o rises.
- It then writes result_o[63:32] (remainder) to HI and result_o[31:0] (quotient) to LO.
- Contains the sequencing FSM, iteration counter, operand latches, sign fix-up and annul handling.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  in  WIDTH  dividend; sampled with start.
- opdata2_i  in  WIDTH  divisor; sampled with start.
- start_i  in  1  request; held high by the execute stage until ready_o is seen.
- annul_i  in  1  abort the current operation (exception or flush).
- result_o  out  2*WIDTH  {remainder, quotient}; valid only while ready_o = 1, otherwise 0.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst = 0, asynchronous, any state): state = FREE, counter = 0, result_o = 0, ready_o = 0, latches cleared.
- All outputs are registered.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i = 1 and annul_i = 0 and opdata2_i = 0, go to BYZERO.
  - If start_i = 1 and annul_i = 0 and opdata2_i != 0, go to ON and latch the operands.
  - Latching for signed mode: store |opdata1_i|, |opdata2_i| (two's-complement negate when bit WIDTH-1 is set), the dividend sign and the quotient sign (XOR of the two operand signs).
  - Initialise the 2*WIDTH+1-bit working register to {0, |dividend|}; counter = 0.
  - Otherwise stay in FREE; ready_o = 0, result_o = 0.
- BYZERO: next edge go to END with result_o = 0 and ready_o = 1. If annul_i = 1, go to FREE instead.
- ON, with annul_i = 0 and counter < WIDTH, each edge performs one restoring step:
  - Shift the working register left 1.
  - Compute trial = upper WIDTH+1 bits minus {0, |divisor|}.
  - If trial >= 0, replace the upper bits with trial and set LSB = 1; else LSB = 0.
  - counter++.
- ON, with counter = WIDTH:
  - Next edge goes to END.
  - result_o = {rem, quo}, where quo is the low WIDTH bits and rem is the upper WIDTH bits.
  - In signed mode, quo is negated if the quotient sign is set, and rem is negated if the dividend was negative.
  - ready_o = 1.
- ON with annul_i = 1: next edge go to FREE; counter = 0, ready_o = 0; the partial result is discarded.
- END: hold result_o and ready_o while start_i = 1. When start_i = 0, the next edge goes to FREE with ready_o = 0 and result_o = 0. annul_i is ignored in END.
- Latency, counting the edge that accepts start as edge 0:
  - ready_o is high after edge WIDTH+1 (edge 33 at WIDTH = 32).
  - Divide-by-zero: ready_o is high after edge 1.
- Input changes after acceptance have no effect; only latched values are used.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No flag is raised.
- Divide-by-zero result is architecturally undefined; this block returns 0 for both halves.
- Remainder sign always follows the dividend; |rem| < |divisor|.
- start_i must not be asserted while the block is busy. Re-assertion in ON or BYZERO has no effect.

Test Plan:
- DIVU 100/7: start at edge 0 → ready_o = 0 through edge 32, ready_o = 1 after edge 33, result_o = {0x00000002, 0x0000000E}.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/−2 → {0x00000001, 0xFFFFFFFD}.
- DIV 5/0 → BYZERO; ready_o = 1 after edge 1, result_o = 0. Drop start_i → ready_o = 0 after the next edge.
- DIVU 0xFFFFFFFF/0x10 with annul_i pulsed at edge 10 → FREE, ready_o never rises. Restart the same operation → {0x0000000F, 0x0FFFFFFF} at start + 33.
- DIV 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}. Change the operands during ON → the result is unchanged.
- Assert rst low mid-ON (edge 20), asynchronously between edges → ready_o = 0 and result_o = 0 immediately, state FREE. After release, DIVU 9/3 → {0, 3} at start + 33. Hold start_i high for 5 cycles in END → ready_o stays 1 and result_o is stable.
